nois_system_nios2_qsys_0_ocimem_arbiter: RTL

Shares the on-chip debug memory (OCI RAM, single port, 1-cycle read latency) between two requesters:
- the JTAG debug path, via the sysclk-domain take_action_ocimem_* pulses and jdo;
- the CPU, via an Avalon-MM slave.
It owns the JTAG address/data registers (MonAReg, MonDReg), sequences the RAM accesses and arbitrates round-robin. It sits beside the JTAG debug module wrapper inside the Nios II OCI block.

---
 rtl/nois_system_nios2_qsys_0_oci_pkg.sv | 21 ++
 rtl/nois_system_nios2_qsys_0_ocimem_jtag_req.sv | 80 ++++++++
 rtl/nois_system_nios2_qsys_0_ocimem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/nois_system_nios2_qsys_0_oci_pkg.sv
// Shared types and jdo field positions for the Nios II OCI memory path.
// No ports: FSM state enum, grant owner enum and jdo bit constants.
package nois_system_nios2_qsys_0_oci_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        CPU_ACK = 2'd2
    } ocimem_state_e;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_JTAG = 1'b1
    } grant_e;

    localparam int JDO_RD_FLAG = 35;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;
    localparam int JDO_ADDR_LO = 17;

endpackage

// File: rtl/nois_system_nios2_qsys_0_ocimem_jtag_req.sv
// JTAG side of the OCI RAM: decodes take_action pulses into MonAReg/MonDReg
// and a single pending request (req/req_wr); ack/ack_rd retire it.
// Ports: clk, reset, take_* pulses, jdo in; ack, ack_rd, rd_data from the
// arbiter; req, req_wr, mon_a, mon_d, overrun out.
module nois_system_nios2_qsys_0_ocimem_jtag_req
    import nois_system_nios2_qsys_0_oci_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              ack,
    input  logic              ack_rd,
    input  logic [31:0]       rd_data,
    output logic              req,
    output logic              req_wr,
    output logic [ADDR_W-1:0] mon_a,
    output logic [31:0]       mon_d,
    output logic              overrun
);

    logic any_ev;
    logic unused_jdo;

    assign any_ev = take_action_ocimem_a | take_no_action_ocimem_a |
                    take_action_ocimem_b;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            req     <= 1'b0;
            req_wr  <= 1'b0;
            mon_a   <= '0;
            mon_d   <= '0;
            overrun <= 1'b0;
        end else begin
            // A retiring request still counts as pending this cycle, so an
            // event landing on the ack cycle is dropped rather than merged.
            if (ack) begin
                req   <= 1'b0;
                mon_a <= mon_a + ADDR_W'(1);
            end
            if (ack_rd)
                mon_d <= rd_data;
            if (req && any_ev)
                overrun <= 1'b1;

            priority case (1'b1)
                take_action_ocimem_b: begin
                    if (!req) begin
                        mon_d  <= jdo[JDO_DATA_HI:JDO_DATA_LO];
                        req    <= 1'b1;
                        req_wr <= 1'b1;
                    end
                end
                take_action_ocimem_a: begin
                    // The address load is applied even when the read is dropped.
                    mon_a <= jdo[JDO_ADDR_LO +: ADDR_W];
                    if (!req && jdo[JDO_RD_FLAG]) begin
                        req    <= 1'b1;
                        req_wr <= 1'b0;
                    end
                end
                take_no_action_ocimem_a: begin
                    if (!req) begin
                        req    <= 1'b1;
                        req_wr <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nois_system_nios2_qsys_0_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI RAM between JTAG and an
// Avalon-MM CPU slave. Ports: clk/reset, JTAG pulses + jdo, avs_* slave,
// ram_* master (1-cycle read latency), MonDReg and jtag_overrun.
module nois_system_nios2_qsys_0_ocimem_arbiter
    import nois_system_nios2_qsys_0_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic [37:0]         jdo,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_waitrequest,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_be,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                jtag_overrun
);

    ocimem_state_e     state;
    ocimem_state_e     state_nxt;
    grant_e            last_grant;
    logic              rd_jtag;
    logic              jtag_req;
    logic              jtag_wr;
    logic              jtag_ack;
    logic              jtag_ack_rd;
    logic              cpu_req;
    logic              jtag_win;
    logic              cpu_win;
    logic [ADDR_W-1:0] MonAReg;

    nois_system_nios2_qsys_0_ocimem_jtag_req #(
        .ADDR_W(ADDR_W)
    ) u_jtag_req (
        .clk                    (clk),
        .reset                  (reset),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .jdo                    (jdo),
        .ack                    (jtag_ack),
        .ack_rd                 (jtag_ack_rd),
        .rd_data                (ram_rdata),
        .req                    (jtag_req),
        .req_wr                 (jtag_wr),
        .mon_a                  (MonAReg),
        .mon_d                  (MonDReg),
        .overrun                (jtag_overrun)
    );

    // Winners are only acted on in IDLE; on a tie the last loser goes first.
    assign cpu_req  = avs_read | avs_write;
    assign jtag_win = jtag_req && (!cpu_req || last_grant == GRANT_CPU);
    assign cpu_win  = cpu_req && !jtag_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= GRANT_CPU;
            rd_jtag      <= 1'b0;
            avs_readdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (jtag_win)
                    last_grant <= GRANT_JTAG;
                else if (cpu_win)
                    last_grant <= GRANT_CPU;
                rd_jtag <= jtag_win;
            end
            if (state == RD_WAIT && !rd_jtag)
                avs_readdata <= ram_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (jtag_win && !jtag_wr)
                    state_nxt = RD_WAIT;
                else if (cpu_win && !avs_write)
                    state_nxt = RD_WAIT;
            end
            RD_WAIT: state_nxt = rd_jtag ? IDLE : CPU_ACK;
            CPU_ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_addr        = '0;
        ram_wr          = 1'b0;
        ram_wdata       = '0;
        ram_be          = '0;
        avs_waitrequest = 1'b1;
        jtag_ack        = 1'b0;
        jtag_ack_rd     = 1'b0;
        // Reset blocks every access and ack in the cycle it is asserted.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (jtag_win) begin
                        ram_addr = MonAReg;
                        if (jtag_wr) begin
                            ram_wr    = 1'b1;
                            ram_wdata = MonDReg;
                            ram_be    = '1;
                            jtag_ack  = 1'b1;
                        end
                    end else if (cpu_win) begin
                        ram_addr = avs_address;
                        if (avs_write) begin
                            ram_wr          = 1'b1;
                            ram_wdata       = avs_writedata;
                            ram_be          = avs_byteenable;
                            avs_waitrequest = 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_jtag) begin
                        jtag_ack    = 1'b1;
                        jtag_ack_rd = 1'b1;
                    end
                end
                CPU_ACK: avs_waitrequest = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
